// File: rtl/lm75_pkg.sv
// Shared types and constants for the LM75 temperature reader: FSM states, quarter phases,
// default sensor address and display clamp limits.
package lm75_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StRdMsb,
    StMAck,
    StRdLsb,
    StMNack,
    StStop,
    StWait
  } state_e;

  // Position inside one I2C bit time
  localparam logic [1:0] QDrive  = 2'd0;
  localparam logic [1:0] QRise   = 2'd1;
  localparam logic [1:0] QSample = 2'd2;
  localparam logic [1:0] QFall   = 2'd3;

  localparam logic [6:0] DefaultDevAddr = 7'h48;

  localparam logic [7:0]  ClampMaxInt  = 8'd99;
  localparam logic [15:0] ClampMaxWord = 16'h6300;

  // Limit a reading to the 0..99 C range the display can show
  function automatic logic [15:0] clamp_reading(input logic [15:0] raw);
    logic [15:0] res;
    if (raw[15]) begin
      res = 16'h0000;
    end else if (raw[15:8] > ClampMaxInt) begin
      res = ClampMaxWord;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-bit tick generator: one-clk qtick every QDIV clocks and a free-running
// 2-bit quarter index that advances on each tick.
module i2c_qtick_gen #(
  parameter int unsigned QDIV = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       qtick,
  output logic [1:0] quarter
);

  localparam int unsigned CntW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(QDIV - 1);

  logic [CntW-1:0] cnt_q;
  logic [1:0]      quarter_q;

  assign qtick   = (cnt_q == CntMax);
  assign quarter = quarter_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      quarter_q <= 2'd0;
    end else if (qtick) begin
      cnt_q     <= '0;
      quarter_q <= quarter_q + 2'd1;
    end else begin
      cnt_q     <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/lm75_temp_reader.sv
// Periodic I2C master reading the LM75 temperature register into the display data word.
// Define LM75_CLAMP_EN to clamp stored readings to 0..99 C.
module lm75_temp_reader
  import lm75_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned I2C_FREQ    = 100_000,
  parameter logic [6:0]  DEV_ADDR    = DefaultDevAddr,
  parameter int unsigned POLL_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        scl,
  inout  wire         sda,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        ack_error
);

  localparam int unsigned QDIV = CLK_FREQ / (4 * I2C_FREQ);

  logic        qtick;
  logic [1:0]  quarter;

  state_e      state_q;
  logic        scl_q;
  logic        sda_oe_q;
  logic        sda_meta_q;
  logic        sda_sync_q;
  logic [7:0]  shreg_q;
  logic [7:0]  msb_q;
  logic [2:0]  bit_cnt_q;
  logic        nack_q;
  logic [31:0] poll_cnt_q;
  logic [15:0] data_q;
  logic        data_valid_q;
  logic        ack_error_q;

  logic [15:0] reading;
  logic [15:0] new_data;
  logic        poll_done;

  i2c_qtick_gen #(
    .QDIV (QDIV)
  ) u_qtick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .qtick   (qtick),
    .quarter (quarter)
  );

  // The LSB is still in the shifter when STOP completes
  assign reading = {msb_q, shreg_q[7], 7'b0};

`ifdef LM75_CLAMP_EN
  assign new_data = clamp_reading(reading);
`else
  assign new_data = reading;
`endif

  assign poll_done = ({1'b0, poll_cnt_q} + 33'd1) >= 33'(POLL_CYCLES);

  assign scl        = scl_q;
  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign ack_error  = ack_error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      scl_q        <= 1'b1;
      sda_oe_q     <= 1'b0;
      shreg_q      <= 8'h00;
      msb_q        <= 8'h00;
      bit_cnt_q    <= 3'd0;
      nack_q       <= 1'b0;
      poll_cnt_q   <= 32'd0;
      data_q       <= 16'h0000;
      data_valid_q <= 1'b0;
      ack_error_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StStart;

        StWait: begin
          if (poll_cnt_q != 32'hFFFF_FFFF) poll_cnt_q <= poll_cnt_q + 32'd1;
          // Leave on a q3 tick so the next START begins on q0
          if (qtick && quarter == QFall && poll_done) state_q <= StStart;
        end

        StStart: begin
          if (qtick) begin
            unique case (quarter)
              QDrive:  sda_oe_q <= 1'b0;
              QRise:   scl_q    <= 1'b1;
              QSample: sda_oe_q <= 1'b1;
              QFall: begin
                scl_q     <= 1'b0;
                shreg_q   <= {DEV_ADDR, 1'b1};
                bit_cnt_q <= 3'd7;
                nack_q    <= 1'b0;
                state_q   <= StAddr;
              end
            endcase
          end
        end

        StStop: begin
          if (qtick) begin
            unique case (quarter)
              QDrive:  sda_oe_q <= 1'b1;
              QRise:   scl_q    <= 1'b1;
              QSample: sda_oe_q <= 1'b0;
              QFall: begin
                if (!nack_q) begin
                  data_q       <= new_data;
                  data_valid_q <= 1'b1;
                  ack_error_q  <= 1'b0;
                end
                poll_cnt_q <= 32'd0;
                state_q    <= StWait;
              end
            endcase
          end
        end

        default: begin
          if (qtick) begin
            unique case (quarter)
              QDrive: begin
                if (state_q == StAddr) begin
                  sda_oe_q <= ~shreg_q[7];
                end else begin
                  sda_oe_q <= (state_q == StMAck);
                end
              end

              QRise: scl_q <= 1'b1;

              QSample: begin
                if (state_q == StAddrAck) begin
                  if (sda_sync_q) begin
                    ack_error_q <= 1'b1;
                    nack_q      <= 1'b1;
                  end
                end else if (state_q == StRdMsb || state_q == StRdLsb) begin
                  shreg_q <= {shreg_q[6:0], sda_sync_q};
                end
              end

              QFall: begin
                scl_q <= 1'b0;
                unique case (state_q)
                  StAddr: begin
                    shreg_q <= {shreg_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd0) state_q <= StAddrAck;
                    else bit_cnt_q <= bit_cnt_q - 3'd1;
                  end
                  StAddrAck: begin
                    bit_cnt_q <= 3'd7;
                    state_q   <= nack_q ? StStop : StRdMsb;
                  end
                  StRdMsb: begin
                    if (bit_cnt_q == 3'd0) begin
                      msb_q   <= shreg_q;
                      state_q <= StMAck;
                    end else begin
                      bit_cnt_q <= bit_cnt_q - 3'd1;
                    end
                  end
                  StMAck: begin
                    bit_cnt_q <= 3'd7;
                    state_q   <= StRdLsb;
                  end
                  StRdLsb: begin
                    if (bit_cnt_q == 3'd0) state_q <= StMNack;
                    else bit_cnt_q <= bit_cnt_q - 3'd1;
                  end
                  StMNack: state_q <= StStop;
                  default: state_q <= StIdle;
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lm75_temp_reader.sv
// Directed bench for lm75_temp_reader with a small LM75 slave model on an open-drain SDA bus.
module tb_lm75_temp_reader;

  localparam int unsigned ClkFreq    = 1_600_000;
  localparam int unsigned I2cFreq    = 100_000;
  localparam int unsigned PollCycles = 160;

`ifdef LM75_CLAMP_EN
  localparam bit ClampOn = 1'b1;
`else
  localparam bit ClampOn = 1'b0;
`endif

  localparam logic [15:0] ExpNeg = ClampOn ? 16'h0000 : 16'hF600;
  localparam logic [15:0] ExpHot = ClampOn ? 16'h6300 : 16'h7D00;
  localparam logic [15:0] Exp100 = ClampOn ? 16'h6300 : 16'h6480;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scl;
  wire         sda_bus;
  logic [15:0] data;
  logic        data_valid;
  logic        ack_error;

  always #5 clk = ~clk;

  lm75_temp_reader #(
    .CLK_FREQ    (ClkFreq),
    .I2C_FREQ    (I2cFreq),
    .DEV_ADDR    (7'h48),
    .POLL_CYCLES (PollCycles)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl        (scl),
    .sda        (sda_bus),
    .data       (data),
    .data_valid (data_valid),
    .ack_error  (ack_error)
  );

  pullup (sda_bus);

  logic       slave_low = 1'b0;
  logic       present;
  logic [7:0] s_msb;
  logic [7:0] s_lsb;
  logic       scl_d = 1'b1;
  logic       sda_d = 1'b1;
  logic       active = 1'b0;
  logic       acked = 1'b0;
  logic [4:0] falls = 5'd0;
  logic [7:0] addr_sh = 8'h00;

  assign sda_bus = (slave_low && reset_n) ? 1'b0 : 1'bz;

  // Slave: count SCL falls after START; period after fall n carries bit n
  always @(posedge clk) begin
    scl_d <= scl;
    sda_d <= sda_bus;
    if (!reset_n) begin
      active    <= 1'b0;
      acked     <= 1'b0;
      slave_low <= 1'b0;
    end else if (scl && scl_d && sda_d && !sda_bus) begin
      active    <= 1'b1;
      acked     <= 1'b0;
      falls     <= 5'd0;
      slave_low <= 1'b0;
    end else if (active && scl_d && !scl) begin
      falls     <= falls + 5'd1;
      slave_low <= 1'b0;
      if (falls == 5'd8) begin
        if (present && addr_sh == {7'h48, 1'b1}) begin
          slave_low <= 1'b1;
          acked     <= 1'b1;
        end
      end else if (acked && falls >= 5'd9 && falls <= 5'd16) begin
        slave_low <= ~s_msb[5'd16 - falls];
      end else if (acked && falls >= 5'd18 && falls <= 5'd25) begin
        slave_low <= ~s_lsb[5'd25 - falls];
      end
      if (falls >= 5'd27) active <= 1'b0;
    end else if (active && !scl_d && scl && falls >= 5'd1 && falls <= 5'd8) begin
      addr_sh <= {addr_sh[6:0], sda_bus};
    end
  end

  int   cyc = 0;
  int   vcnt = 0;
  int   stop_cnt = 0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    scl_m <= scl;
    sda_m <= sda_bus;
    if (data_valid) vcnt <= vcnt + 1;
    if (reset_n && scl && scl_m && !sda_m && sda_bus) stop_cnt <= stop_cnt + 1;
  end

  int checks = 0;
  int fails  = 0;
  int rel    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!data_valid && n < limit);
  endtask

  task automatic wait_ackerr(input int limit);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack_error && n < limit);
  endtask

  task automatic wait_stop(input int limit);
    int n;
    int target;
    n = 0;
    target = stop_cnt + 1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (stop_cnt < target && n < limit);
    chk("stop_seen", 32'(stop_cnt >= target), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    present = 1'b0;
    s_msb   = 8'h00;
    s_lsb   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda_bus), 32'd1);
    chk("rst_data", 32'(data), 32'h0000);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_ack_error", 32'(ack_error), 32'd0);

    // No slave: NACK, STOP, nothing stored
    @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    wait_ackerr(400);
    chk("nack1_time", 32'(cyc - rel), 32'd156);
    wait_stop(200);
    repeat (8) @(posedge clk);
    #1;
    chk("nack1_ack_error", 32'(ack_error), 32'd1);
    chk("nack1_data", 32'(data), 32'h0000);
    chk("nack1_no_valid", 32'(vcnt), 32'd0);

    present = 1'b1;
    s_msb   = 8'h19;
    s_lsb   = 8'h80;
    wait_valid(1000);
    chk("rd1_time", 32'(cyc - rel), 32'd800);
    chk("rd1_data", 32'(data), 32'h1980);
    chk("rd1_ack_error", 32'(ack_error), 32'd0);
    @(posedge clk);
    #1;
    chk("rd1_pulse_width", 32'(data_valid), 32'd0);

    // Second poll NACKs: data holds
    present = 1'b0;
    wait_ackerr(600);
    chk("nack2_time", 32'(cyc - rel), 32'd1116);
    wait_stop(200);
    repeat (8) @(posedge clk);
    #1;
    chk("nack2_data_held", 32'(data), 32'h1980);
    chk("nack2_ack_error", 32'(ack_error), 32'd1);
    chk("nack2_no_valid", 32'(vcnt), 32'd1);

    present = 1'b1;
    s_msb   = 8'h20;
    s_lsb   = 8'h00;
    wait_valid(1000);
    chk("rd2_time", 32'(cyc - rel), 32'd1760);
    chk("rd2_data", 32'(data), 32'h2000);
    chk("rd2_ack_error", 32'(ack_error), 32'd0);

    s_msb = 8'hF6;
    s_lsb = 8'h00;
    wait_valid(1000);
    chk("neg_time", 32'(cyc - rel), 32'd2384);
    chk("neg_data", 32'(data), 32'(ExpNeg));

    s_msb = 8'h7D;
    wait_valid(1000);
    chk("hot_time", 32'(cyc - rel), 32'd3008);
    chk("hot_data", 32'(data), 32'(ExpHot));

    s_msb = 8'h64;
    s_lsb = 8'h80;
    wait_valid(1000);
    chk("int100_data", 32'(data), 32'(Exp100));

    s_msb = 8'h63;
    s_lsb = 8'hFF;
    wait_valid(1000);
    chk("int99_time", 32'(cyc - rel), 32'd4256);
    chk("int99_data", 32'(data), 32'h6380);

    // Reset on the SCL fall of LSB bit 3 while the slave holds SDA low
    s_msb = 8'h19;
    s_lsb = 8'h00;
    repeat (528) @(posedge clk);
    #1;
    chk("pre_rst_scl", 32'(scl), 32'd0);
    chk("pre_rst_sda", 32'(sda_bus), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_scl", 32'(scl), 32'd1);
    chk("mid_rst_sda", 32'(sda_bus), 32'd1);
    chk("mid_rst_data", 32'(data), 32'h0000);
    chk("mid_rst_valid", 32'(data_valid), 32'd0);
    repeat (4) @(posedge clk);
    s_lsb = 8'h80;
    @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    wait_valid(1000);
    chk("restart_time", 32'(cyc - rel), 32'd464);
    chk("restart_data", 32'(data), 32'h1980);
    chk("restart_ack_error", 32'(ack_error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
